// File: rtl/rs232_pkg.sv
// +----------------------------------------------------------------------------+
// | rs232_pkg                                                                  |
// | Line-level constants and link FSM state encoding for rs232_link_ctrl.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rs232_pkg;

  // Modem-control lines are active-low on the wire.
  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    WAIT_DSR = 3'd1,
    WAIT_DCD = 3'd2,
    ONLINE   = 3'd3,
    HANGUP   = 3'd4,
    FAULT    = 3'd5
  } link_state_t;

endpackage

`default_nettype wire

// File: rtl/rs232_sync.sv
// +----------------------------------------------------------------------------+
// | rs232_sync                                                                 |
// | Multi-flop synchronizer for one asynchronous line input, resets to MARK.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs232_sync
  import rs232_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {SYNC_STAGES{MARK}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rs232_link_ctrl.sv
// +----------------------------------------------------------------------------+
// | rs232_link_ctrl                                                            |
// | DTE modem-control sequencer: DTR/DSR/DCD link-up, hangup, CTS TX gating,   |
// | RTS flow control. Optional DSR timeout: define RS232_LINK_CTRL_TIMEOUT_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs232_link_ctrl
  import rs232_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DSR_TIMEOUT = 1_000_000,
  parameter int HOLD_CYCLES = 1000,
  parameter int LEVEL_W     = 5,
  parameter int RTS_HIGH_WM = 12,
  parameter int RTS_LOW_WM  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               hangup,
  input  logic               s_tx_valid,
  output logic               s_tx_ready,
  output logic               m_tx_valid,
  input  logic               m_tx_ready,
  input  logic [LEVEL_W-1:0] rx_level,
  output logic               rts,
  output logic               dtr,
  input  logic               cts,
  input  logic               dsr,
  input  logic               dcd,
  output logic [2:0]         state,
  output logic               link_up,
  output logic               fault
);

  localparam int                c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0]  c_high_wm   = LEVEL_W'(RTS_HIGH_WM);
  localparam logic [LEVEL_W-1:0]  c_low_wm    = LEVEL_W'(RTS_LOW_WM);

  logic w_cts_s, w_dsr_s, w_dcd_s;

  rs232_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cts (.clk(clk), .rst(rst), .d(cts), .q(w_cts_s));
  rs232_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dsr (.clk(clk), .rst(rst), .d(dsr), .q(w_dsr_s));
  rs232_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dcd (.clk(clk), .rst(rst), .d(dcd), .q(w_dcd_s));

  link_state_t         r_state, w_next;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic                r_dtr, r_rts, r_link_up, r_tx_allow;
  logic                w_abort, w_pending, w_dsr_expired;

  assign w_abort   = hangup | ~enable;
  assign w_pending = m_tx_valid & ~m_tx_ready;

`ifdef RS232_LINK_CTRL_TIMEOUT_EN
  localparam int                c_to_w    = (DSR_TIMEOUT > 1) ? $clog2(DSR_TIMEOUT) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(DSR_TIMEOUT - 1);

  logic [c_to_w-1:0] r_dsr_cnt;
  logic              r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dsr_cnt <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_dsr_cnt <= (r_state == WAIT_DSR) ? r_dsr_cnt + 1'b1 : '0;
      // Sticky until the next attempt to bring the link up.
      if (w_next == FAULT) begin
        r_fault <= 1'b1;
      end else if (w_next == WAIT_DSR && r_state != WAIT_DSR) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign w_dsr_expired = (r_dsr_cnt == c_to_last);
  assign fault         = r_fault;
`else
  assign w_dsr_expired = 1'b0;
  assign fault         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OFF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OFF: begin
        if (enable) w_next = WAIT_DSR;
      end
      WAIT_DSR: begin
        if (w_abort)                 w_next = HANGUP;
        else if (w_dsr_s == SPACE)   w_next = WAIT_DCD;
        else if (w_dsr_expired)      w_next = FAULT;
      end
      WAIT_DCD: begin
        if (w_abort || w_dsr_s == MARK) w_next = HANGUP;
        else if (w_dcd_s == SPACE)      w_next = ONLINE;
      end
      ONLINE: begin
        if (w_abort || w_dsr_s == MARK || w_dcd_s == MARK) w_next = HANGUP;
      end
      HANGUP: begin
        if (r_hold_cnt == c_hold_last) w_next = OFF;
      end
      FAULT: begin
        if (!enable) w_next = OFF;
      end
      default: w_next = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_dtr      <= MARK;
      r_rts      <= MARK;
      r_link_up  <= 1'b0;
      r_tx_allow <= 1'b0;
    end else begin
      r_hold_cnt <= (r_state == HANGUP) ? r_hold_cnt + 1'b1 : '0;
      r_dtr      <= (w_next == WAIT_DSR || w_next == WAIT_DCD || w_next == ONLINE) ? SPACE : MARK;
      r_link_up  <= (w_next == ONLINE);

      // Hysteresis between the watermarks; on entry only the high mark matters.
      if (w_next != ONLINE) begin
        r_rts <= MARK;
      end else if (r_state != ONLINE) begin
        r_rts <= (rx_level < c_high_wm) ? SPACE : MARK;
      end else if (rx_level >= c_high_wm) begin
        r_rts <= MARK;
      end else if (rx_level <= c_low_wm) begin
        r_rts <= SPACE;
      end

      // A pending offer keeps the gate open past a CTS drop, but not past leaving ONLINE.
      r_tx_allow <= (w_next == ONLINE) && ((w_cts_s == SPACE) || (r_tx_allow && w_pending));
    end
  end

  assign m_tx_valid = s_tx_valid & r_tx_allow;
  assign s_tx_ready = m_tx_ready & r_tx_allow;
  assign rts        = r_rts;
  assign dtr        = r_dtr;
  assign link_up    = r_link_up;
  assign state      = r_state;

endmodule

`default_nettype wire
